// File: rtl/peripheral_axi4_pkg.sv
// rtl/peripheral_axi4_pkg.sv - AXI4 encodings, FSM state types and address helper
package peripheral_axi4_pkg;

    localparam logic [1:0] AXI_BURST_TYPE_FIXED  = 2'b00;
    localparam logic [1:0] AXI_BURST_TYPE_INCR   = 2'b01;

    localparam logic [3:0] AXI_BURST_LENGTH_1    = 4'd0;
    localparam logic [3:0] AXI_BURST_LENGTH_2    = 4'd1;
    localparam logic [3:0] AXI_BURST_LENGTH_4    = 4'd3;
    localparam logic [3:0] AXI_BURST_LENGTH_8    = 4'd7;
    localparam logic [3:0] AXI_BURST_LENGTH_16   = 4'd15;

    localparam logic [1:0] AXI_LOCK_NORMAL       = 2'b00;
    localparam logic [2:0] AXI_PROTECTION_NORMAL = 3'b000;

    localparam logic [1:0] AXI_RESP_OKAY         = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR       = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // FIXED bursts stay on one address; every other burst type advances by the beat size
    function automatic logic [31:0] axi_next_addr(input logic [31:0] addr,
                                                  input logic [2:0]  size,
                                                  input logic [1:0]  burst);
        return (burst == AXI_BURST_TYPE_FIXED) ? addr : addr + (32'd1 << size);
    endfunction

endpackage

// File: rtl/peripheral_bfm_slave_memory_axi4.sv
// rtl/peripheral_bfm_slave_memory_axi4.sv - word memory, byte-enable write port, registered read port
module peripheral_bfm_slave_memory_axi4 #(
    parameter int MEM_DEPTH = 256,
    parameter int IDX_W     = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic             re,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);

    logic [31:0] mem [MEM_DEPTH];

    // Byte-lane writes; contents are deliberately not reset
    always_ff @(posedge aclk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read register only updates when a new beat is loaded, so rdata holds under back-pressure
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdata <= 32'h0;
        end else if (re) begin
            rdata <= mem[ridx];
        end
    end

endmodule

// File: rtl/peripheral_bfm_slave_generic_axi4.sv
// rtl/peripheral_bfm_slave_generic_axi4.sv - AXI4 memory responder with independent write/read FSMs
module peripheral_bfm_slave_generic_axi4
    import peripheral_axi4_pkg::*;
#(
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  awid,
    input  logic [31:0] awadr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wrdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);

    localparam int          IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_DEPTH);

    // 33-bit subtraction so an address below BASE_ADDR goes "negative" and fails the compare
    function automatic logic in_range(input logic [31:0] a);
        return ({1'b0, a} - {1'b0, BASE_ADDR}) < {1'b0, MEM_BYTES};
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic beat_bad(input logic [31:0] a, input logic [2:0] size);
        return !in_range(a) || (size > 3'd2);
    endfunction

    // Sideband fields this responder does not act on
    logic unused_sideband;
    assign unused_sideband = ^{awlock ^ AXI_LOCK_NORMAL, awcache, awprot ^ AXI_PROTECTION_NORMAL,
                               wid, arlock, arcache, arprot};

    w_state_t    w_state;
    logic [3:0]  w_id;
    logic [31:0] w_addr;
    logic [3:0]  w_len;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic [3:0]  w_cnt;
    logic        w_err;

    r_state_t    r_state;
    logic [31:0] r_addr;
    logic [3:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [3:0]  r_cnt;
    logic        r_oor;

    logic             mem_we;
    logic [IDX_W-1:0] mem_widx;
    logic             mem_re;
    logic [IDX_W-1:0] mem_ridx;
    logic [31:0]      mem_rdata;

    logic        w_beat_hs;
    logic        w_is_last;
    logic        w_beat_bad;
    logic        r_ar_hs;
    logic        r_beat_hs;
    logic [31:0] r_next_addr;
    logic [3:0]  r_next_cnt;

    assign w_beat_hs   = wvalid && wready;
    assign w_is_last   = (w_cnt == w_len);
    assign w_beat_bad  = beat_bad(w_addr, w_size) || (wlast != w_is_last);
    assign mem_we      = w_beat_hs && !w_beat_bad;
    assign mem_widx    = word_idx(w_addr);

    assign r_ar_hs     = arvalid && arready;
    assign r_beat_hs   = rvalid && rready;
    assign r_next_addr = axi_next_addr(r_addr, r_size, r_burst);
    assign r_next_cnt  = r_cnt + 4'd1;
    assign mem_re      = r_ar_hs || (r_beat_hs && !rlast);
    assign mem_ridx    = (r_state == R_IDLE) ? word_idx(araddr) : word_idx(r_next_addr);

    // Out-of-range beats read as zero regardless of what the index aliases to
    assign rdata = r_oor ? 32'h0 : mem_rdata;

    peripheral_bfm_slave_memory_axi4 #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_mem (
        .aclk    (aclk),
        .aresetn (aresetn),
        .we      (mem_we),
        .widx    (mem_widx),
        .wdata   (wrdata),
        .wstrb   (wstrb),
        .re      (mem_re),
        .ridx    (mem_ridx),
        .rdata   (mem_rdata)
    );

    // Write FSM: accept AW, absorb len+1 W beats, then hold B until bready
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            w_id    <= 4'h0;
            w_addr  <= 32'h0;
            w_len   <= 4'h0;
            w_size  <= 3'h0;
            w_burst <= 2'h0;
            w_cnt   <= 4'h0;
            w_err   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= 4'h0;
            bresp   <= 2'h0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        w_id    <= awid;
                        w_addr  <= awadr;
                        w_len   <= awlen;
                        w_size  <= awsize;
                        w_burst <= awburst;
                        w_cnt   <= 4'h0;
                        w_err   <= 1'b0;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat_hs) begin
                        w_err  <= w_err || w_beat_bad;
                        w_addr <= axi_next_addr(w_addr, w_size, w_burst);
                        w_cnt  <= w_cnt + 4'd1;
                        if (w_is_last) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= w_id;
                            bresp   <= (w_err || w_beat_bad) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: beat 0 is loaded at AR accept, later beats as each R beat is taken
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            r_addr  <= 32'h0;
            r_len   <= 4'h0;
            r_size  <= 3'h0;
            r_burst <= 2'h0;
            r_cnt   <= 4'h0;
            r_oor   <= 1'b0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rid     <= 4'h0;
            rresp   <= 2'h0;
            rlast   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (r_ar_hs) begin
                        r_addr  <= araddr;
                        r_len   <= arlen;
                        r_size  <= arsize;
                        r_burst <= arburst;
                        r_cnt   <= 4'h0;
                        r_oor   <= !in_range(araddr);
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rid     <= arid;
                        rlast   <= (arlen == AXI_BURST_LENGTH_1);
                        rresp   <= beat_bad(araddr, arsize) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_beat_hs) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr <= r_next_addr;
                            r_cnt  <= r_next_cnt;
                            r_oor  <= !in_range(r_next_addr);
                            rlast  <= (r_next_cnt == r_len);
                            rresp  <= beat_bad(r_next_addr, r_size) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_bfm_slave_generic_axi4.sv
// tb/tb_peripheral_bfm_slave_generic_axi4.sv - directed table-driven bench for the AXI4 memory responder
module tb_peripheral_bfm_slave_generic_axi4;
    import peripheral_axi4_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  awid;
    logic [31:0] awadr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wrdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    peripheral_bfm_slave_generic_axi4 #(
        .MEM_DEPTH (256),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .aclk    (aclk),    .aresetn (aresetn),
        .awid    (awid),    .awadr   (awadr),   .awlen   (awlen),   .awsize  (awsize),
        .awburst (awburst), .awlock  (awlock),  .awcache (awcache), .awprot  (awprot),
        .awvalid (awvalid), .awready (awready),
        .wid     (wid),     .wrdata  (wrdata),  .wstrb   (wstrb),   .wlast   (wlast),
        .wvalid  (wvalid),  .wready  (wready),
        .bid     (bid),     .bresp   (bresp),   .bvalid  (bvalid),  .bready  (bready),
        .arid    (arid),    .araddr  (araddr),  .arlen   (arlen),   .arsize  (arsize),
        .arburst (arburst), .arlock  (arlock),  .arcache (arcache), .arprot  (arprot),
        .arvalid (arvalid), .arready (arready),
        .rid     (rid),     .rdata   (rdata),   .rresp   (rresp),   .rlast   (rlast),
        .rvalid  (rvalid),  .rready  (rready)
    );

    always #5 aclk = ~aclk;

    localparam int TMO = 50;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit               wr;
        logic [31:0]      addr;
        logic [3:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0]       strb;
        logic [3:0][31:0] d;
        logic [3:0][1:0]  r;
    } vec_t;

    vec_t vt [19];

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [3:0] len,
                                input logic [2:0] size, input logic [1:0] burst,
                                input logic [3:0] strb, input logic [127:0] d, input logic [7:0] r);
        vec_t v;
        v.wr = wr; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
        v.strb = strb; v.d = d; v.r = r;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timeout after %0d cycles, want handshake", name, TMO);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                            input logic [127:0] data, input logic [1:0] exp_resp,
                            input int hold, input string tag);
        int n;
        @(negedge aclk);
        awid = id; awadr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < TMO) begin @(negedge aclk); n++; end
        if (n >= TMO) timeout_fail({tag, " aw"});
        @(negedge aclk);
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wrdata = data[b*32 +: 32]; wstrb = strb; wlast = (b == int'(len)); wvalid = 1'b1;
            n = 0;
            while (!wready && n < TMO) begin @(negedge aclk); n++; end
            if (n >= TMO) timeout_fail({tag, " w"});
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = (hold == 0);
        n = 0;
        while (!bvalid && n < TMO) begin @(negedge aclk); n++; end
        if (n >= TMO) timeout_fail({tag, " b"});
        check({tag, " b_latency"}, 32'(n), 32'd0);
        for (int h = 0; h < hold; h++) begin
            check({tag, " hold bvalid"}, 32'(bvalid), 32'd1);
            check({tag, " hold bresp"}, 32'(bresp), 32'(exp_resp));
            @(negedge aclk);
        end
        bready = 1'b1;
        check({tag, " bresp"}, 32'(bresp), 32'(exp_resp));
        check({tag, " bid"}, 32'(bid), 32'(id));
        @(negedge aclk);
        bready = 1'b0;
        check({tag, " bvalid drop"}, 32'(bvalid), 32'd0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [127:0] exp_d, input logic [7:0] exp_r,
                           input int hold, input string tag);
        int n;
        @(negedge aclk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < TMO) begin @(negedge aclk); n++; end
        if (n >= TMO) timeout_fail({tag, " ar"});
        @(negedge aclk);
        arvalid = 1'b0;
        rready = (hold == 0);
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (!rvalid && n < TMO) begin @(negedge aclk); n++; end
            if (n >= TMO) timeout_fail({tag, " r"});
            if (b == 0) begin
                check({tag, " r_latency"}, 32'(n), 32'd0);
                for (int h = 0; h < hold; h++) begin
                    check({tag, " hold rvalid"}, 32'(rvalid), 32'd1);
                    check({tag, " hold rdata"}, rdata, exp_d[31:0]);
                    @(negedge aclk);
                end
                rready = 1'b1;
            end
            check($sformatf("%s rdata[%0d]", tag, b), rdata, exp_d[b*32 +: 32]);
            check($sformatf("%s rresp[%0d]", tag, b), 32'(rresp), 32'(exp_r[b*2 +: 2]));
            check($sformatf("%s rlast[%0d]", tag, b), 32'(rlast), 32'(b == int'(len)));
            check($sformatf("%s rid[%0d]", tag, b), 32'(rid), 32'(id));
            @(negedge aclk);
        end
        rready = 1'b0;
        check({tag, " rvalid drop"}, 32'(rvalid), 32'd0);
    endtask

    initial begin
        aresetn = 1'b0;
        awid = 0; awadr = 0; awlen = 0; awsize = 0; awburst = 0; awlock = 0; awcache = 0;
        awprot = 0; awvalid = 0; wid = 0; wrdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
        bready = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arlock = 0;
        arcache = 0; arprot = 0; arvalid = 0; rready = 0;

        vt[0]  = mk(1, 32'h10,  4'd0, 3'd2, AXI_BURST_TYPE_INCR,  4'hF, 128'hDEADBEEF, 8'h00);
        vt[1]  = mk(0, 32'h10,  4'd0, 3'd2, AXI_BURST_TYPE_INCR,  4'hF, 128'hDEADBEEF, 8'h00);
        vt[2]  = mk(1, 32'h20,  4'd0, 3'd2, AXI_BURST_TYPE_INCR,  4'hF, 128'hFFFFFFFF, 8'h00);
        vt[3]  = mk(1, 32'h20,  4'd0, 3'd2, AXI_BURST_TYPE_INCR,  4'h3, 128'h12345678, 8'h00);
        vt[4]  = mk(0, 32'h20,  4'd0, 3'd2, AXI_BURST_TYPE_INCR,  4'hF, 128'hFFFF5678, 8'h00);
        vt[5]  = mk(1, 32'h40,  4'd3, 3'd2, AXI_BURST_TYPE_INCR,  4'hF,
                    {32'd4, 32'd3, 32'd2, 32'd1}, 8'h00);
        vt[6]  = mk(0, 32'h40,  4'd3, 3'd2, AXI_BURST_TYPE_INCR,  4'hF,
                    {32'd4, 32'd3, 32'd2, 32'd1}, 8'h00);
        vt[7]  = mk(1, 32'h54,  4'd0, 3'd2, AXI_BURST_TYPE_INCR,  4'hF, 128'hCAFEF00D, 8'h00);
        vt[8]  = mk(1, 32'h50,  4'd3, 3'd2, AXI_BURST_TYPE_FIXED, 4'hF,
                    {32'd8, 32'd7, 32'd6, 32'd5}, 8'h00);
        vt[9]  = mk(0, 32'h50,  4'd0, 3'd2, AXI_BURST_TYPE_INCR,  4'hF, 128'd8, 8'h00);
        vt[10] = mk(0, 32'h54,  4'd0, 3'd2, AXI_BURST_TYPE_INCR,  4'hF, 128'hCAFEF00D, 8'h00);
        vt[11] = mk(1, 32'h400, 4'd0, 3'd2, AXI_BURST_TYPE_INCR,  4'hF, 128'h55555555, 8'h02);
        vt[12] = mk(0, 32'h400, 4'd0, 3'd2, AXI_BURST_TYPE_INCR,  4'hF, 128'h0, 8'h02);
        vt[13] = mk(1, 32'h3F8, 4'd3, 3'd2, AXI_BURST_TYPE_INCR,  4'hF,
                    {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 8'h02);
        vt[14] = mk(0, 32'h3F8, 4'd3, 3'd2, AXI_BURST_TYPE_INCR,  4'hF,
                    {32'h0, 32'h0, 32'hA2, 32'hA1}, 8'hA0);
        vt[15] = mk(1, 32'h60,  4'd0, 3'd2, AXI_BURST_TYPE_INCR,  4'hF, 128'h11111111, 8'h00);
        vt[16] = mk(1, 32'h60,  4'd0, 3'd3, AXI_BURST_TYPE_INCR,  4'hF, 128'h22222222, 8'h02);
        vt[17] = mk(0, 32'h60,  4'd0, 3'd2, AXI_BURST_TYPE_INCR,  4'hF, 128'h11111111, 8'h00);
        vt[18] = mk(0, 32'h40,  4'd1, 3'd2, AXI_BURST_TYPE_FIXED, 4'hF,
                    {32'd1, 32'd1}, 8'h00);

        repeat (3) @(negedge aclk);
        check("reset awready", 32'(awready), 32'd0);
        check("reset arready", 32'(arready), 32'd0);
        check("reset bvalid",  32'(bvalid),  32'd0);
        check("reset rvalid",  32'(rvalid),  32'd0);
        check("reset rdata",   rdata,        32'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        check("idle awready", 32'(awready), 32'd1);
        check("idle arready", 32'(arready), 32'd1);

        for (int i = 0; i < 19; i++) begin
            if (vt[i].wr)
                do_write(4'(i), vt[i].addr, vt[i].len, vt[i].size, vt[i].burst, vt[i].strb,
                         vt[i].d, vt[i].r[0], 0, $sformatf("v%0d wr", i));
            else
                do_read(4'(i), vt[i].addr, vt[i].len, vt[i].size, vt[i].burst,
                        vt[i].d, vt[i].r, 0, $sformatf("v%0d rd", i));
        end

        // Back-pressure: B and R held for 5 cycles while their ready is low
        do_write(4'h5, 32'h70, 4'd0, 3'd2, AXI_BURST_TYPE_INCR, 4'hF, 128'h5A5A5A5A,
                 AXI_RESP_OKAY, 5, "hold wr");
        do_read(4'h6, 32'h70, 4'd0, 3'd2, AXI_BURST_TYPE_INCR, 128'h5A5A5A5A, 8'h00, 5, "hold rd");

        // Reset in the middle of a write burst and a read burst
        @(negedge aclk);
        awid = 4'h3; awadr = 32'h80; awlen = 4'd3; awsize = 3'd2; awburst = AXI_BURST_TYPE_INCR;
        awvalid = 1'b1;
        arid = 4'h4; araddr = 32'h40; arlen = 4'd3; arsize = 3'd2; arburst = AXI_BURST_TYPE_INCR;
        arvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0; arvalid = 1'b0;
        wrdata = 32'h0000_0BAD; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        @(negedge aclk);
        check("midburst wready before reset", 32'(wready), 32'd1);
        check("midburst rvalid before reset", 32'(rvalid), 32'd1);
        aresetn = 1'b0;
        #1;
        check("midreset awready", 32'(awready), 32'd0);
        check("midreset wready",  32'(wready),  32'd0);
        check("midreset bvalid",  32'(bvalid),  32'd0);
        check("midreset rvalid",  32'(rvalid),  32'd0);
        check("midreset arready", 32'(arready), 32'd0);
        wvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        check("postreset awready", 32'(awready), 32'd1);
        check("postreset bvalid",  32'(bvalid),  32'd0);
        do_write(4'hA, 32'h80, 4'd0, 3'd2, AXI_BURST_TYPE_INCR, 4'hF, 128'h0BADF00D,
                 AXI_RESP_OKAY, 0, "postreset wr");
        do_read(4'hA, 32'h80, 4'd0, 3'd2, AXI_BURST_TYPE_INCR, 128'h0BADF00D, 8'h00, 0,
                "postreset rd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
